// File: rtl/bus_pkg.sv
// Shared types and default constants for the data-memory bus controller.
package bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [31:0] DEF_RAM_BASE  = 32'h1001_0000;
  localparam logic [31:0] DEF_RAM_SIZE  = 32'h0000_4000;
  localparam logic [15:0] DEF_MMIO_BASE = 16'hFF00;
  localparam int unsigned DEF_TIMEOUT   = 255;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RAM_WAIT = 3'd1,
    ST_IO       = 3'd2,
    ST_ERR      = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_RAM  = 2'd1,
    REG_IO   = 2'd2
  } region_e;

  // Latched CPU request, held for the whole access
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic              we;
  } req_t;

endpackage

// File: rtl/data_bus_ctrl_if.sv
// CPU-side, RAM-side and MMIO-side signals of the data bus controller.
interface data_bus_ctrl_if;
  import bus_pkg::*;

  logic [ADDR_W-1:0] iAddress;
  logic [DATA_W-1:0] iWriteData;
  logic              iWriteEnable;
  logic              iReadEnable;
  logic [BE_W-1:0]   iByteEnable;
  logic [DATA_W-1:0] oReadData;
  logic              oStall;
  logic              oBusError;

  logic              oMemReq;
  logic              oMemWe;
  logic [ADDR_W-1:0] oMemAddr;
  logic [DATA_W-1:0] oMemWData;
  logic [BE_W-1:0]   oMemBE;
  logic              iMemAck;
  logic [DATA_W-1:0] iMemRData;

  logic              oIoSel;
  logic              oIoWe;
  logic [ADDR_W-1:0] oIoAddr;
  logic [DATA_W-1:0] oIoWData;
  logic [BE_W-1:0]   oIoBE;
  logic [DATA_W-1:0] iIoRData;

  // Controller view
  modport slave (
    input  iAddress, iWriteData, iWriteEnable, iReadEnable, iByteEnable,
    output oReadData, oStall, oBusError,
    output oMemReq, oMemWe, oMemAddr, oMemWData, oMemBE,
    input  iMemAck, iMemRData,
    output oIoSel, oIoWe, oIoAddr, oIoWData, oIoBE,
    input  iIoRData
  );

  // CPU / memory / MMIO environment view
  modport master (
    output iAddress, iWriteData, iWriteEnable, iReadEnable, iByteEnable,
    input  oReadData, oStall, oBusError,
    input  oMemReq, oMemWe, oMemAddr, oMemWData, oMemBE,
    output iMemAck, iMemRData,
    input  oIoSel, oIoWe, oIoAddr, oIoWData, oIoBE,
    output iIoRData
  );

endinterface

// File: rtl/bus_addr_decode.sv
// Combinational address-to-region decoder; RAM takes priority over MMIO.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
  parameter logic [31:0] RAM_SIZE  = DEF_RAM_SIZE,
  parameter logic [15:0] MMIO_BASE = DEF_MMIO_BASE
) (
  input  logic [ADDR_W-1:0] addr,
  output region_e           region_c
);

  // End bound kept at 33 bits so a region touching the top of memory cannot wrap
  localparam logic [32:0] RAM_END = 33'(RAM_BASE) + 33'(RAM_SIZE);

  // Region select
  always_comb begin
    region_c = REG_NONE;
    if ((addr >= RAM_BASE) && (33'(addr) < RAM_END)) begin
      region_c = REG_RAM;
    end else if (addr[31:16] == MMIO_BASE) begin
      region_c = REG_IO;
    end
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// Data-memory bus controller: routes CPU accesses to RAM (req/ack) or MMIO
// (single-cycle select) and stalls the CPU until the access completes.
module data_bus_ctrl
  import bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
  parameter logic [31:0] RAM_SIZE  = DEF_RAM_SIZE,
  parameter logic [15:0] MMIO_BASE = DEF_MMIO_BASE,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input logic            iCLK,
  input logic            iRST_N,
  data_bus_ctrl_if.slave bus
);

  state_e             state, state_next;
  region_e            region_c;
  req_t               req_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic [DATA_W-1:0]  rdata_q;
  logic               mem_req_q, mem_we_q, io_sel_q, io_we_q, bus_err_q;
  logic               access_c, stall_c, we_next_c;

  assign access_c = bus.iReadEnable | bus.iWriteEnable;

  bus_addr_decode #(
    .RAM_BASE (RAM_BASE),
    .RAM_SIZE (RAM_SIZE),
    .MMIO_BASE(MMIO_BASE)
  ) u_decode (
    .addr    (bus.iAddress),
    .region_c(region_c)
  );

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state, stall and write qualifier for the upcoming cycle
  always_comb begin
    state_next = state;
    stall_c    = 1'b0;
    we_next_c  = req_q.we;
    case (state)
      ST_IDLE: begin
        we_next_c = bus.iWriteEnable;
        if (access_c) begin
          stall_c = 1'b1;
          case (region_c)
            REG_RAM: state_next = ST_RAM_WAIT;
            REG_IO:  state_next = ST_IO;
            default: state_next = ST_ERR;
          endcase
        end
      end
      ST_RAM_WAIT: begin
        stall_c = 1'b1;
        if (bus.iMemAck)                           state_next = ST_DONE;
        else if (wait_cnt == CNT_W'(TIMEOUT - 1))  state_next = ST_ERR;
      end
      ST_IO: begin
        stall_c    = 1'b1;
        state_next = ST_DONE;
      end
      ST_ERR: begin
        stall_c    = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latch, captured when an access is accepted
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      req_q <= '0;
    end else if ((state == ST_IDLE) && access_c) begin
      req_q <= '{addr:  bus.iAddress,
                 wdata: bus.iWriteData,
                 be:    bus.iByteEnable,
                 we:    bus.iWriteEnable};
    end
  end

  // Ack-less RAM wait counter, cleared while idle
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wait_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wait_cnt <= '0;
    end else if ((state == ST_RAM_WAIT) && !bus.iMemAck) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Bus strobes registered from the next state
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      io_sel_q  <= 1'b0;
      io_we_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      mem_req_q <= (state_next == ST_RAM_WAIT);
      mem_we_q  <= (state_next == ST_RAM_WAIT) && we_next_c;
      io_sel_q  <= (state_next == ST_IO);
      io_we_q   <= (state_next == ST_IO) && we_next_c;
      bus_err_q <= (state_next == ST_ERR);
    end
  end

  // Read data: updated only by completing reads, cleared by an error
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rdata_q <= '0;
    end else begin
      case (state)
        ST_RAM_WAIT: if (bus.iMemAck && !req_q.we) rdata_q <= bus.iMemRData;
        ST_IO:       if (!req_q.we)                rdata_q <= bus.iIoRData;
        ST_ERR:      rdata_q <= '0;
        default:     ;
      endcase
    end
  end

  // Stall is gated by reset so an aborted access releases the CPU immediately
  assign bus.oStall    = stall_c & iRST_N;
  assign bus.oReadData = rdata_q;
  assign bus.oBusError = bus_err_q;

  assign bus.oMemReq   = mem_req_q;
  assign bus.oMemWe    = mem_we_q;
  assign bus.oMemAddr  = req_q.addr;
  assign bus.oMemWData = req_q.wdata;
  assign bus.oMemBE    = req_q.be;

  assign bus.oIoSel    = io_sel_q;
  assign bus.oIoWe     = io_we_q;
  assign bus.oIoAddr   = req_q.addr;
  assign bus.oIoWData  = req_q.wdata;
  assign bus.oIoBE     = req_q.be;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed bench for data_bus_ctrl with a 4-cycle RAM timeout.
module tb_data_bus_ctrl;
  import bus_pkg::*;

  logic iCLK;
  logic iRST_N;
  int   n_vec  = 0;
  int   n_miss = 0;

  data_bus_ctrl_if bus();

  data_bus_ctrl #(.TIMEOUT(4)) dut (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .bus   (bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.iReadEnable  = 1'b0;
    bus.iWriteEnable = 1'b0;
    bus.iMemAck      = 1'b0;
  endtask

  // Runs one access from the IDLE negedge through DONE; returns at the next IDLE negedge
  task automatic do_access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic we, input logic re,
                           input int ack_at, input logic [31:0] mdata, input logic [31:0] iodata,
                           input bit hold,
                           output int stall_n, output int req_n, output int sel_n,
                           output int err_n, output logic [31:0] rd, output bit stable);
    int waits;
    bit done;
    stall_n = 0; req_n = 0; sel_n = 0; err_n = 0; rd = '0; stable = 1'b1;
    waits = 0; done = 1'b0;
    bus.iAddress     = addr;
    bus.iWriteData   = wdata;
    bus.iByteEnable  = be;
    bus.iWriteEnable = we;
    bus.iReadEnable  = re;
    bus.iIoRData     = iodata;
    bus.iMemAck      = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (!bus.oStall) begin
        done = 1'b1;
        rd   = bus.oReadData;
      end else begin
        stall_n++;
        if (bus.oMemReq) begin
          req_n++;
          waits++;
          if (bus.oMemAddr !== addr || bus.oMemWData !== wdata ||
              bus.oMemBE !== be || bus.oMemWe !== we) stable = 1'b0;
          bus.iMemAck   = (waits == ack_at);
          bus.iMemRData = (waits == ack_at) ? mdata : 32'hDEAD_BEEF;
        end else begin
          bus.iMemAck = 1'b0;
        end
        if (bus.oIoSel) begin
          sel_n++;
          if (bus.oIoAddr !== addr || bus.oIoWData !== wdata ||
              bus.oIoBE !== be || bus.oIoWe !== we) stable = 1'b0;
        end
        if (bus.oBusError) err_n++;
        @(negedge iCLK);
      end
    end
    if (!done) chk({tag, "_done"}, 32'd0, 32'd1);
    bus.iMemAck = 1'b0;
    if (!hold) drive_idle();
    @(negedge iCLK);
  endtask

  int          s, q, io, e;
  logic [31:0] rd;
  bit          st;

  initial begin
    bus.iAddress = '0; bus.iWriteData = '0; bus.iByteEnable = '0;
    bus.iMemRData = '0; bus.iIoRData = '0;
    drive_idle();
    iRST_N = 1'b0;
    @(negedge iCLK);
    @(negedge iCLK);
    chk("rst_stall",  32'(bus.oStall),    32'd0);
    chk("rst_memreq", 32'(bus.oMemReq),   32'd0);
    chk("rst_iosel",  32'(bus.oIoSel),    32'd0);
    chk("rst_err",    32'(bus.oBusError), 32'd0);
    chk("rst_rdata",  bus.oReadData,      32'd0);
    chk("rst_maddr",  bus.oMemAddr,       32'd0);
    iRST_N = 1'b1;
    @(negedge iCLK);

    // RAM read, ack on the 3rd wait cycle
    do_access("rd_ram", 32'h1001_0008, 32'h0, 4'hF, 1'b0, 1'b1, 3, 32'hCAFE_F00D, 32'h0, 1'b0,
              s, q, io, e, rd, st);
    chk("rd_ram_stall", 32'(s), 32'd4);
    chk("rd_ram_req",   32'(q), 32'd3);
    chk("rd_ram_data",  rd, 32'hCAFE_F00D);
    chk("rd_ram_stab",  32'(st), 32'd1);
    chk("rd_ram_reqlo", 32'(bus.oMemReq), 32'd0);

    // RAM write, immediate ack, lane 1 only
    do_access("wr_ram", 32'h1001_0004, 32'h0000_AB00, 4'b0010, 1'b1, 1'b0, 1, 32'h0, 32'h0, 1'b0,
              s, q, io, e, rd, st);
    chk("wr_ram_stall", 32'(s), 32'd2);
    chk("wr_ram_req",   32'(q), 32'd1);
    chk("wr_ram_stab",  32'(st), 32'd1);
    chk("wr_ram_rd",    rd, 32'hCAFE_F00D);

    // MMIO read
    do_access("rd_io", 32'hFF00_0010, 32'h0, 4'hF, 1'b0, 1'b1, 0, 32'h0, 32'h1234_5678, 1'b0,
              s, q, io, e, rd, st);
    chk("rd_io_stall", 32'(s), 32'd2);
    chk("rd_io_sel",   32'(io), 32'd1);
    chk("rd_io_req",   32'(q), 32'd0);
    chk("rd_io_stab",  32'(st), 32'd1);
    chk("rd_io_data",  rd, 32'h1234_5678);

    // Unmapped read
    do_access("rd_none", 32'h0000_0000, 32'h0, 4'hF, 1'b0, 1'b1, 0, 32'h0, 32'h0, 1'b0,
              s, q, io, e, rd, st);
    chk("rd_none_stall", 32'(s), 32'd2);
    chk("rd_none_err",   32'(e), 32'd1);
    chk("rd_none_bus",   32'(q + io), 32'd0);
    chk("rd_none_data",  rd, 32'd0);

    // Last RAM word
    do_access("rd_top", 32'h1001_3FFC, 32'h0, 4'hF, 1'b0, 1'b1, 2, 32'h55AA_55AA, 32'h0, 1'b0,
              s, q, io, e, rd, st);
    chk("rd_top_stall", 32'(s), 32'd3);
    chk("rd_top_data",  rd, 32'h55AA_55AA);

    // One past the RAM region
    do_access("rd_end", 32'h1001_4000, 32'h0, 4'hF, 1'b0, 1'b1, 1, 32'h0, 32'h0, 1'b0,
              s, q, io, e, rd, st);
    chk("rd_end_err",  32'(e), 32'd1);
    chk("rd_end_req",  32'(q), 32'd0);
    chk("rd_end_data", rd, 32'd0);

    // Both enables high behaves as a write
    do_access("wr_both", 32'h1001_0000, 32'h1122_3344, 4'hF, 1'b1, 1'b1, 2, 32'hFFFF_FFFF, 32'h0, 1'b0,
              s, q, io, e, rd, st);
    chk("wr_both_stall", 32'(s), 32'd3);
    chk("wr_both_stab",  32'(st), 32'd1);
    chk("wr_both_rd",    rd, 32'd0);

    do_access("rd_pre", 32'h1001_0020, 32'h0, 4'hF, 1'b0, 1'b1, 1, 32'hA5A5_0001, 32'h0, 1'b0,
              s, q, io, e, rd, st);
    chk("rd_pre_data", rd, 32'hA5A5_0001);

    // RAM timeout
    do_access("rd_tmo", 32'h1001_0010, 32'h0, 4'hF, 1'b0, 1'b1, 0, 32'h0, 32'h0, 1'b0,
              s, q, io, e, rd, st);
    chk("rd_tmo_stall", 32'(s), 32'd6);
    chk("rd_tmo_req",   32'(q), 32'd4);
    chk("rd_tmo_err",   32'(e), 32'd1);
    chk("rd_tmo_data",  rd, 32'd0);

    // Late ack while idle is ignored
    bus.iMemAck   = 1'b1;
    bus.iMemRData = 32'hBAD0_BAD0;
    repeat (3) @(negedge iCLK);
    chk("late_stall", 32'(bus.oStall),   32'd0);
    chk("late_req",   32'(bus.oMemReq),  32'd0);
    chk("late_data",  bus.oReadData,     32'd0);
    bus.iMemAck = 1'b0;

    do_access("rd_low", 32'h1000_FFFC, 32'h0, 4'hF, 1'b0, 1'b1, 1, 32'h0, 32'h0, 1'b0,
              s, q, io, e, rd, st);
    chk("rd_low_err", 32'(e), 32'd1);

    do_access("rd_after", 32'h1001_0030, 32'h0, 4'hF, 1'b0, 1'b1, 1, 32'h600D_F00D, 32'h0, 1'b0,
              s, q, io, e, rd, st);
    chk("rd_after_stall", 32'(s), 32'd2);
    chk("rd_after_data",  rd, 32'h600D_F00D);

    // Reset in the middle of a RAM wait
    bus.iAddress = 32'h1001_0040; bus.iReadEnable = 1'b1; bus.iWriteEnable = 1'b0;
    @(negedge iCLK);
    #1;
    chk("mid_req",   32'(bus.oMemReq), 32'd1);
    chk("mid_stall", 32'(bus.oStall),  32'd1);
    #1 iRST_N = 1'b0;
    #1;
    chk("mid_rst_req",   32'(bus.oMemReq), 32'd0);
    chk("mid_rst_stall", 32'(bus.oStall),  32'd0);
    chk("mid_rst_data",  bus.oReadData,    32'd0);
    @(negedge iCLK);
    drive_idle();
    iRST_N = 1'b1;
    @(negedge iCLK);

    // Back-to-back read then write with enables never dropping
    do_access("b2b_rd", 32'h1001_0000, 32'h0, 4'hF, 1'b0, 1'b1, 1, 32'h0F0F_0F0F, 32'h0, 1'b1,
              s, q, io, e, rd, st);
    chk("b2b_rd_stall", 32'(s), 32'd2);
    chk("b2b_rd_data",  rd, 32'h0F0F_0F0F);
    do_access("b2b_wr", 32'h1001_0004, 32'h0000_00EE, 4'b0001, 1'b1, 1'b0, 2, 32'h0, 32'h0, 1'b0,
              s, q, io, e, rd, st);
    chk("b2b_wr_stall", 32'(s), 32'd3);
    chk("b2b_wr_req",   32'(q), 32'd2);
    chk("b2b_wr_stab",  32'(st), 32'd1);
    chk("b2b_wr_rd",    rd, 32'h0F0F_0F0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/data_bus_ctrl.md
# data_bus_ctrl

Data-memory bus controller sitting directly downstream of the multicycle RISC-V datapath's data bus (address, write data, read/write enables, byte enables). Decodes each access into RAM, MMIO or unmapped space. Drives a req/ack handshake to a variable-latency RAM, or a single-cycle select to the MMIO bus. Returns read data and a stall signal that freezes the control FSM until the access completes.

## Interface
- RAM_BASE, 32'h1001_0000, first byte address of RAM region
- RAM_SIZE, 32'h0000_4000, RAM region size in bytes (power of two)
- MMIO_BASE, 16'hFF00, upper 16 address bits selecting MMIO
- TIMEOUT, 255, max RAM wait cycles before error (1..255)
- iCLK  in  1  clock, rising edge
- iRST_N  in  1  reset, asynchronous, active-low
- iAddress  in  32  CPU byte address
- iWriteData  in  32  CPU store data, already lane-aligned
- iWriteEnable  in  1  CPU store request
- iReadEnable  in  1  CPU load/fetch request
- iByteEnable  in  4  CPU byte lanes
- oReadData  out  32  registered read data
- oStall  out  1  hold CPU control FSM
- oBusError  out  1  one-cycle pulse on unmapped access or timeout
- oMemReq, oMemWe  out  1 each  RAM request, write qualifier
- oMemAddr  out  32  latched address; oMemWData out 32; oMemBE out 4
- iMemAck  in  1  RAM completion; iMemRData in 32 read data, valid with ack
- oIoSel, oIoWe  out  1 each  MMIO select, write qualifier
- oIoAddr  out  32; oIoWData out 32; oIoBE out 4
- iIoRData  in  32  MMIO read data, valid during oIoSel

## Operation
- States: IDLE, RAM_WAIT, IO, ERR, DONE.
- IDLE: access = iReadEnable | iWriteEnable. Access latches address, data, BE, and write = iWriteEnable; next state by region:
  - RAM: RAM_BASE <= addr < RAM_BASE+RAM_SIZE -> RAM_WAIT.
  - MMIO: addr[31:16]==MMIO_BASE -> IO.
  - Otherwise -> ERR.
- Both enables high: treated as write.
- RAM_WAIT: oMemReq=1, oMemWe=latched write. On iMemAck: capture iMemRData (reads only), -> DONE. Wait counter increments each cycle without ack; reaching TIMEOUT -> ERR. Ack in the timeout cycle: ack wins.
- IO: oIoSel=1 for exactly one cycle; capture iIoRData (reads) -> DONE.
- ERR: oBusError=1; oReadData <= 0 -> DONE.
- DONE: oStall=0; -> IDLE. Enables still high on return to IDLE start a new access (back-to-back).
- oStall = (IDLE & access) | RAM_WAIT | IO | ERR; combinational, so stall is high in the request cycle.
- Write data is never modified; byte lanes pass through unchanged.
- oReadData holds its last value until the next read completes. A write does not change it.

## Timing
- Reset: state IDLE; all outputs 0; oReadData 0; counter 0. Reset mid-access drops oMemReq/oIoSel asynchronously, with no completion.
- Best-case latency for every access type: 3 cycles (IDLE, RAM_WAIT/IO/ERR, DONE); stall high for 2.
- RAM with ack after k wait cycles: stall high for k+1 cycles.
- oMemAddr/WData/BE/We remain stable for the whole time oMemReq is high. oMemReq falls in the cycle after ack is sampled.
- Timeout: ERR entered after TIMEOUT ack-less RAM_WAIT cycles; oMemReq drops there. A late ack after that is ignored.

## Structure
- Shared package bus_pkg: state encoding (3-bit), region codes (REG_RAM, REG_IO, REG_NONE), default base constants.
- Sub-module bus_addr_decode: combinational, address -> region code, parameterised by RAM_BASE/RAM_SIZE/MMIO_BASE.
- Top contains the FSM, request latches, wait counter and read-data register.

## Test plan
- RAM read 0x1001_0008, ack on 3rd RAM_WAIT cycle with data 0xCAFEF00D -> oStall high 4 cycles, oReadData=0xCAFEF00D in DONE, oMemReq low afterwards.
- RAM write 0x1001_0004, data 0x0000AB00, BE 4'b0010, immediate ack -> oMemWe=1, BE passed unchanged, 3-cycle access, oReadData unchanged.
- MMIO read 0xFF00_0010, iIoRData=0x12345678 -> oIoSel high exactly 1 cycle, oReadData=0x12345678.
- Unmapped read 0x0000_0000 -> oBusError pulse 1 cycle, oReadData=0, no oMemReq/oIoSel.
- RAM read with no ack, TIMEOUT=4 -> ERR after 4 wait cycles, oBusError pulse; later ack ignored; next access proceeds normally.
- Reset asserted while in RAM_WAIT -> oMemReq and oStall drop immediately. After release, a back-to-back read/write pair completes correctly.
